syscall_unit: RTL and testbench
===============================

// Module: syscall_unit
// PURPOSE
//  Multi-cycle SPIM-style syscall service unit for the single-cycle core; sits beside the datapath.
//  Triggered by Control's SYSENABLE; stalls the PC and borrows the data-memory port via SYSMEM/SYSADDR.
//  Drives SYS_REGWRITE/SYSDATA into the write-back mux ($v0). Presents console I/O as valid/ready streams.
// PARAMETERS
//  MAX_STR_LEN  256   max bytes emitted per print_string; longer strings are truncated, err_trunc set
//  TIMEOUT      1024  read_int wait bound in cycles (used only with SYSCALL_TIMEOUT_EN)
// PORTS
//  clock         in   1   core clock; all state updates on posedge
//  reset_n       in   1   asynchronous, active-low reset
//  sys_enable    in   1   SYSENABLE from Control; held high while the syscall instruction is held
//  v0            in   32  service code ($v0), sampled at trigger
//  a0            in   32  argument ($a0), sampled at trigger
//  stall         out  1   hold PC; core must not advance while high
//  sys_mem       out  1   SYSMEM: selects sys_addr onto the data-memory address mux
//  sys_addr      out  32  SYSADDR: byte address, word-aligned ({addr[31:2],2'b00})
//  mem_rdata     in   32  data-memory read word (combinational read of sys_addr)
//  sys_regwrite  out  1   SYS_REGWRITE: write sys_data to $v0 this edge
//  sys_data      out  32  SYSDATA
//  in_valid      in   1   console integer input valid
//  in_data       in   32  console integer
//  in_ready      out  1   high in S_RDINT; transfer on in_valid && in_ready
//  out_valid     out  1   console output valid; out_kind/out_data held until out_ready
//  out_ready     in   1   console consumer ready
//  out_kind      out  1   0 = char (out_data[7:0]), 1 = integer (out_data)
//  out_data      out  32  output payload
//  halt          out  1   sticky after exit (10); cleared only by reset
//  err           out  1   sticky: unknown code, truncation, or timeout
// BEHAVIOUR
//  Reset: state S_IDLE; stall, sys_mem, sys_regwrite, in_ready, out_valid, halt, err = 0;
//   sys_addr, sys_data, out_data = 0; out_kind = 0. Reset mid-service aborts silently; nothing is written.
//  stall = (S_IDLE & sys_enable & !halt) | (state != S_IDLE & state != S_DONE).
//  S_IDLE: sys_enable & !halt -> latch code/arg; next state by code:
//   1 print_int -> S_EMIT (kind 1, data a0); 11 print_char -> S_EMIT (kind 0, a0[7:0]);
//   4 print_string -> S_FETCH (ptr = a0, count = 0); 5 read_int -> S_RDINT;
//   10 exit -> S_DONE, set halt; any other code -> S_DONE, set err.
//  S_EMIT: out_valid = 1; on out_ready -> S_DONE (string mode: -> S_FETCH, ptr+1, count+1).
//  S_FETCH: sys_mem = 1, sys_addr = word of ptr; byte = mem_rdata[8*ptr[1:0] +: 8] (little-endian).
//   byte == 0 -> S_DONE; count == MAX_STR_LEN -> S_DONE, set err; else -> S_EMIT with the byte.
//   One FETCH cycle per byte; the word is not cached.
//  S_RDINT: in_ready = 1; on in_valid capture in_data -> S_DONE with a pending $v0 write.
//  S_DONE: stall = 0 for exactly one cycle (PC advances); sys_regwrite = 1 only for read_int;
//   sys_enable ignored in this cycle; -> S_IDLE. Minimum syscall latency is 2 cycles.
//  While halt = 1: sys_enable is ignored and stall stays 0; the core's own halt logic stops fetch.
//  ptr arithmetic is 32-bit and wraps at 2^32; count is clog2(MAX_STR_LEN+1) bits.
// CONFIGURATION
//  SYSCALL_TIMEOUT_EN defined: S_RDINT counts cycles; at TIMEOUT with no transfer -> S_DONE,
//   sys_data = 0 written to $v0, err set. Undefined: S_RDINT waits indefinitely, no counter logic.
// STRUCTURE
//  syscall_pkg: service-code localparams (SYS_PRINT_INT=1, SYS_PRINT_STR=4, SYS_READ_INT=5,
//   SYS_EXIT=10, SYS_PRINT_CHAR=11), state encoding, OUT_KIND_CHAR/OUT_KIND_INT.
//  Sub-module syscall_byte_sel: mem_rdata + ptr[1:0] -> byte and is_nul; combinational.
// TESTING
//  v0=11, a0=0x41, out_ready=1 -> one out beat kind 0 data 0x41; stall high 2 cycles, then 1 low cycle.
//  v0=4, a0=0x1001, memory "Hi\0" at 0x1001 -> beats 0x48, 0x69; sys_addr 0x1000 each FETCH; no err.
//  v0=5, in_valid raised after 7 cycles with 0xFFFFFFF6 -> sys_regwrite for 1 cycle in S_DONE, sys_data 0xFFFFFFF6.
//  v0=4, 300-byte non-NUL string, MAX_STR_LEN=256 -> exactly 256 beats, err=1, stall released.
//  v0=10 -> halt=1; a following sys_enable with v0=11 gives no stall and no beat; reset_n low clears halt.
//  out_ready held low 5 cycles during print_int -> out_valid/out_data stable; reset_n pulse mid-wait -> all outputs 0.

Source files
------------

// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall service unit: service codes, FSM states, output kinds.
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_READ_INT   = 32'd5;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  localparam logic OUT_KIND_CHAR = 1'b0;
  localparam logic OUT_KIND_INT  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_FETCH,
    S_RDINT,
    S_DONE
  } state_t;

endpackage

// File: rtl/syscall_byte_sel.sv
// Little-endian byte lane select from a memory word, with NUL detect for string termination.
module syscall_byte_sel (
  input  logic [31:0] word,
  input  logic [1:0]  sel,
  output logic [7:0]  byte_val,
  output logic        is_nul
);

  always_comb begin
    byte_val = word[8*sel +: 8];
    is_nul   = (byte_val == 8'h00);
  end

endmodule

// File: rtl/syscall_unit.sv
// SPIM-style syscall service unit: console I/O streams, string fetch over the data port, exit/halt.
// Optional read_int timeout is enabled by defining SYSCALL_TIMEOUT_EN.
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int unsigned MAX_STR_LEN = 256,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sys_enable,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        sys_mem,
  output logic [31:0] sys_addr,
  input  logic [31:0] mem_rdata,
  output logic        sys_regwrite,
  output logic [31:0] sys_data,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_kind,
  output logic [31:0] out_data,
  output logic        halt,
  output logic        err
);

  localparam int unsigned CW = $clog2(MAX_STR_LEN + 1);

  state_t        state;
  logic [31:0]   ptr;
  logic [CW-1:0] count;
  logic          str_mode;
  logic          rd_pending;
  logic [7:0]    fetch_byte;
  logic          fetch_nul;

`ifdef SYSCALL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`endif

  syscall_byte_sel u_byte_sel (
    .word     (mem_rdata),
    .sel      (ptr[1:0]),
    .byte_val (fetch_byte),
    .is_nul   (fetch_nul)
  );

  // Everything below is a pure decode of registered state, so no new combinational paths from inputs
  // except the idle-trigger term of stall, which must act in the same cycle as SYSENABLE.
  assign stall        = ((state == S_IDLE) && sys_enable && !halt) ||
                        ((state != S_IDLE) && (state != S_DONE));
  assign sys_mem      = (state == S_FETCH);
  assign sys_addr     = {ptr[31:2], 2'b00};
  assign in_ready     = (state == S_RDINT);
  assign out_valid    = (state == S_EMIT);
  assign sys_regwrite = (state == S_DONE) && rd_pending;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      count      <= '0;
      str_mode   <= 1'b0;
      rd_pending <= 1'b0;
      sys_data   <= '0;
      out_kind   <= OUT_KIND_CHAR;
      out_data   <= '0;
      halt       <= 1'b0;
      err        <= 1'b0;
`ifdef SYSCALL_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (sys_enable && !halt) begin
            str_mode   <= 1'b0;
            rd_pending <= 1'b0;
            case (v0)
              SYS_PRINT_INT: begin
                out_kind <= OUT_KIND_INT;
                out_data <= a0;
                state    <= S_EMIT;
              end
              SYS_PRINT_CHAR: begin
                out_kind <= OUT_KIND_CHAR;
                out_data <= {24'h0, a0[7:0]};
                state    <= S_EMIT;
              end
              SYS_PRINT_STR: begin
                out_kind <= OUT_KIND_CHAR;
                ptr      <= a0;
                count    <= '0;
                str_mode <= 1'b1;
                state    <= S_FETCH;
              end
              SYS_READ_INT: begin
`ifdef SYSCALL_TIMEOUT_EN
                tcnt  <= '0;
`endif
                state <= S_RDINT;
              end
              SYS_EXIT: begin
                halt  <= 1'b1;
                state <= S_DONE;
              end
              default: begin
                err   <= 1'b1;
                state <= S_DONE;
              end
            endcase
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            if (str_mode) begin
              ptr   <= ptr + 32'd1;
              count <= count + 1'b1;
              state <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end

        // NUL terminates before the length limit is considered, so an exact-length string is not an error.
        S_FETCH: begin
          if (fetch_nul) begin
            state <= S_DONE;
          end else if (count == CW'(MAX_STR_LEN)) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            out_data <= {24'h0, fetch_byte};
            state    <= S_EMIT;
          end
        end

        S_RDINT: begin
          if (in_valid) begin
            sys_data   <= in_data;
            rd_pending <= 1'b1;
            state      <= S_DONE;
          end
`ifdef SYSCALL_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            sys_data   <= '0;
            rd_pending <= 1'b1;
            err        <= 1'b1;
            state      <= S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end

        S_DONE: begin
          rd_pending <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Scoreboard bench for syscall_unit: expected console beats and $v0 writes are queued by stimulus, checked by monitors.
module tb_syscall_unit;
  import syscall_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sys_enable = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  logic        stall;
  logic        sys_mem;
  logic [31:0] sys_addr;
  logic [31:0] mem_rdata;
  logic        sys_regwrite;
  logic [31:0] sys_data;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_kind;
  logic [31:0] out_data;
  logic        halt;
  logic        err;

  int tests = 0;
  int fails = 0;

  logic [32:0] beat_q[$];
  logic [31:0] rw_q[$];
  logic [7:0]  mem [0:8191];
  logic [12:0] widx;
  logic        chk_addr = 1'b0;
  logic [31:0] exp_addr = '0;

  always #5 clock = ~clock;

  syscall_unit #(.MAX_STR_LEN(256), .TIMEOUT(1024)) dut (
    .clock(clock), .reset_n(reset_n), .sys_enable(sys_enable), .v0(v0), .a0(a0),
    .stall(stall), .sys_mem(sys_mem), .sys_addr(sys_addr), .mem_rdata(mem_rdata),
    .sys_regwrite(sys_regwrite), .sys_data(sys_data), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_data(out_data), .halt(halt), .err(err)
  );

  assign widx      = {sys_addr[12:2], 2'b00};
  assign mem_rdata = {mem[widx + 13'd3], mem[widx + 13'd2], mem[widx + 13'd1], mem[widx]};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Console output monitor: one comparison per accepted beat.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (beat_q.size() == 0) check("spurious_beat", {31'h0, out_kind, out_data}, 64'h0);
      else check("out_beat", {31'h0, out_kind, out_data}, {31'h0, beat_q.pop_front()});
    end
    if (reset_n && sys_regwrite) begin
      if (rw_q.size() == 0) check("spurious_regwrite", {32'h0, sys_data}, 64'h0);
      else check("regwrite_data", {32'h0, sys_data}, {32'h0, rw_q.pop_front()});
    end
    if (chk_addr && sys_mem) check("fetch_addr", {32'h0, sys_addr}, {32'h0, exp_addr});
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Issue one syscall and hold SYSENABLE until stall drops; returns the number of stalled cycles.
  task automatic do_sys(input logic [31:0] code, input logic [31:0] arg, input int budget, output int hi);
    bit released;
    @(posedge clock);
    #1 v0 = code; a0 = arg; sys_enable = 1'b1;
    hi = 0;
    released = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!stall) begin
        released = 1'b1;
        break;
      end
      hi++;
    end
    if (!released) check("stall_release_timeout", 64'h0, 64'h1);
    @(posedge clock);
    #1 sys_enable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h1001] = 8'h48;
    mem[13'h1002] = 8'h69;
    for (int i = 0; i < 300; i++) mem[13'h1100 + 13'(i)] = 8'h41 + 8'(i % 26);

    do_reset();
    @(negedge clock);
    check("reset_ctrl", {56'h0, stall, sys_mem, sys_regwrite, in_ready, out_valid, out_kind, halt, err}, 64'h0);
    check("reset_addr_data", {sys_addr, sys_data}, 64'h0);
    check("reset_out_data", {32'h0, out_data}, 64'h0);

    // print_char
    beat_q.push_back({OUT_KIND_CHAR, 32'h41});
    do_sys(SYS_PRINT_CHAR, 32'h0000_0141, 20, hi);
    check("char_stall_cycles", 64'(hi), 64'd2);

    // print_string "Hi" at an unaligned address
    beat_q.push_back({OUT_KIND_CHAR, 32'h48});
    beat_q.push_back({OUT_KIND_CHAR, 32'h69});
    exp_addr = 32'h1000;
    chk_addr = 1'b1;
    do_sys(SYS_PRINT_STR, 32'h1001, 50, hi);
    chk_addr = 1'b0;
    check("str_stall_cycles", 64'(hi), 64'd6);
    check("str_no_err", {63'h0, err}, 64'h0);

    // read_int with input arriving after 7 cycles
    rw_q.push_back(32'hFFFF_FFF6);
    fork
      do_sys(SYS_READ_INT, 32'h0, 100, hi);
      begin
        bit got;
        repeat (7) @(posedge clock);
        #2 in_valid = 1'b1; in_data = 32'hFFFF_FFF6;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clock);
          if (in_ready) begin
            got = 1'b1;
            break;
          end
        end
        if (!got) check("in_ready_timeout", 64'h0, 64'h1);
        @(posedge clock);
        #1 in_valid = 1'b0;
      end
    join
    check("rdint_stall_cycles", 64'(hi), 64'd7);

    // print_int under 5 cycles of backpressure
    out_ready = 1'b0;
    beat_q.push_back({OUT_KIND_INT, 32'hDEAD_BEEF});
    fork
      do_sys(SYS_PRINT_INT, 32'hDEAD_BEEF, 50, hi);
      begin
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clock);
          check("bp_hold", {30'h0, out_valid, out_kind, out_data}, {30'h0, 1'b1, OUT_KIND_INT, 32'hDEAD_BEEF});
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    check("bp_stall_cycles", 64'(hi), 64'd7);

    // 300-byte string truncated at 256 beats
    for (int i = 0; i < 256; i++) beat_q.push_back({OUT_KIND_CHAR, 32'(8'h41 + 8'(i % 26))});
    do_sys(SYS_PRINT_STR, 32'h1100, 2000, hi);
    check("trunc_stall_cycles", 64'(hi), 64'd514);
    check("trunc_err", {63'h0, err}, 64'h1);
    check("trunc_beats_left", 64'(beat_q.size()), 64'd0);

    // unknown code
    do_reset();
    do_sys(32'd7, 32'h0, 20, hi);
    check("unknown_stall_cycles", 64'(hi), 64'd1);
    check("unknown_err", {62'h0, err, halt}, 64'h2);

    // exit, then ignored syscall, then reset clears halt
    do_reset();
    do_sys(SYS_EXIT, 32'h0, 20, hi);
    check("exit_halt", {62'h0, halt, err}, 64'h2);
    @(posedge clock);
    #1 v0 = SYS_PRINT_CHAR; a0 = 32'h5A; sys_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("halted_ignore", {62'h0, stall, out_valid}, 64'h0);
    end
    @(posedge clock);
    #1 sys_enable = 1'b0;
    do_reset();
    @(negedge clock);
    check("halt_cleared", {63'h0, halt}, 64'h0);

    // reset pulse while print_int is waiting on out_ready
    out_ready = 1'b0;
    @(posedge clock);
    #1 v0 = SYS_PRINT_INT; a0 = 32'h1234_5678; sys_enable = 1'b1;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clock);
    check("pre_reset_valid", {63'h0, out_valid}, 64'h1);
    #1 reset_n = 1'b0; sys_enable = 1'b0;
    #1;
    check("midreset_ctrl", {56'h0, stall, sys_mem, sys_regwrite, in_ready, out_valid, out_kind, halt, err}, 64'h0);
    check("midreset_data", {sys_data, out_data}, 64'h0);
    @(posedge clock);
    #1 reset_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("post_reset_idle", {62'h0, stall, out_valid}, 64'h0);

    check("queues_drained", 64'(beat_q.size() + rw_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
